// File: rtl/upw_oe_sequencer.sv
// rtl/upw_oe_sequencer.sv - sequenced bring-up of the user-project IO output-enable vector
//
// Purpose:
//   Holds every pad as an input for a settle window after reset. It then turns
//   output enables on in groups of GROUP_SIZE bits, with STEP_GAP clocks between
//   groups, to limit simultaneous switching. Once the ramp is complete, a new
//   direction mask can be loaded through a valid/ready handshake. Bits that the
//   new mask disables turn off at once. Bits that it newly enables ramp in again
//   group by group.
//
// Ports:
//   clk        in     system clock
//   rst_n      in     asynchronous active-low reset
//   vccd1      inout  1.8V supply (USE_POWER_PINS only)
//   vssd1      inout  digital ground (USE_POWER_PINS only)
//   cfg_valid  in     new direction mask offered
//   cfg_mask   in     requested mask, 1 = output enabled
//   cfg_ready  out    mask can be accepted this cycle
//   out_en     out    registered output-enable vector to the pads
//   busy       out    sequencing in progress (not in RUN)
//   done       out    out_en equals the target (in RUN)

module upw_oe_sequencer #(
  parameter int NUM_INS       = 3,
  parameter int NUM_OUTS      = 14,
  parameter int NUM_IOS       = 17,
  parameter int SETTLE_CYCLES = 16,
  parameter int GROUP_SIZE    = 4,
  parameter int STEP_GAP      = 2
) (
`ifdef USE_POWER_PINS
  inout  wire                vccd1,
  inout  wire                vssd1,
`endif
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  input  logic [NUM_IOS-1:0] cfg_mask,
  output logic               cfg_ready,
  output logic [NUM_IOS-1:0] out_en,
  output logic               busy,
  output logic               done
);

  localparam int NG   = (NUM_IOS + GROUP_SIZE - 1) / GROUP_SIZE;
  localparam int SW   = $clog2(SETTLE_CYCLES + 1);
  localparam int GW   = $clog2(NG + 1);
  localparam int GAPW = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;

  localparam logic [SW-1:0]      SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [GW-1:0]      GRP_LAST    = GW'(NG - 1);
  localparam logic [GAPW-1:0]    GAP_RELOAD  = GAPW'(STEP_GAP - 1);
  // Input pads can never be driven, so every target is filtered through this.
  localparam logic [NUM_IOS-1:0] OUT_MASK    = {{NUM_OUTS{1'b1}}, {NUM_INS{1'b0}}};

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_RAMP   = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SW-1:0]      settle_q, settle_d;
  logic [GW-1:0]      grp_q, grp_d;
  logic [GAPW-1:0]    gap_q, gap_d;
  logic [NUM_IOS-1:0] target_q, target_d;
  logic [NUM_IOS-1:0] out_en_q, out_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;
  logic [NUM_IOS-1:0] group_mask;
  logic [NUM_IOS-1:0] new_target;

  // A bit belongs to the current group when its index divided by GROUP_SIZE
  // equals grp. Each bit is evaluated on its own, so a short last group is
  // clipped automatically.
  always_comb begin
    group_mask = '0;
    for (int i = 0; i < NUM_IOS; i++) begin
      group_mask[i] = (GW'(i / GROUP_SIZE) == grp_q);
    end
  end

  assign new_target = cfg_mask & OUT_MASK;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    grp_d    = grp_q;
    gap_d    = gap_q;
    target_d = target_q;
    out_en_d = out_en_q;

    case (state_q)
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_RAMP;
          grp_d   = '0;
          gap_d   = '0;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end

      ST_RAMP: begin
        if (gap_q == '0) begin
          out_en_d = out_en_q | (target_q & group_mask);
          grp_d    = grp_q + GW'(1);
          gap_d    = GAP_RELOAD;
          // The edge that applies the final group also completes the ramp.
          if (grp_q == GRP_LAST) begin
            state_d = ST_RUN;
          end
        end else begin
          gap_d = gap_q - GAPW'(1);
        end
      end

      ST_RUN: begin
        if (cfg_valid && ready_q) begin
          target_d = new_target;
          // Disables take effect at once; new enables wait for the ramp.
          out_en_d = out_en_q & new_target;
          state_d  = ST_RAMP;
          grp_d    = '0;
          gap_d    = '0;
        end
      end

      default: begin
        state_d  = ST_SETTLE;
        settle_d = '0;
        out_en_d = '0;
      end
    endcase

    // Status outputs are registered and follow the next state, so they change
    // on the same edge as the state they describe.
    busy_d  = (state_d != ST_RUN);
    done_d  = (state_d == ST_RUN);
    ready_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_SETTLE;
      settle_q <= '0;
      grp_q    <= '0;
      gap_q    <= '0;
      target_q <= OUT_MASK;
      out_en_q <= '0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      grp_q    <= grp_d;
      gap_q    <= gap_d;
      target_q <= target_d;
      out_en_q <= out_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign out_en    = out_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_ready = ready_q;

endmodule

// File: tb/tb_upw_oe_sequencer.sv
// tb/tb_upw_oe_sequencer.sv - self-checking bench for upw_oe_sequencer

module tb_upw_oe_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic [16:0] cfg_mask;
  logic        cfg_ready;
  logic [16:0] out_en;
  logic        busy;
  logic        done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic        valid;
    logic [16:0] mask;
    logic [16:0] exp_oe;
    logic        exp_busy;
    logic        exp_done;
    logic        exp_ready;
    string       name;
  } vec_t;

  vec_t tbl[$];
  vec_t bringup_tbl[$];
  vec_t sb[$];

  upw_oe_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_mask  (cfg_mask),
    .cfg_ready (cfg_ready),
    .out_en    (out_en),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Published ramp schedule: k edges after the ramp starts, group g lands at k = 1 + 2g.
  function automatic logic [16:0] ramp_oe(input int k);
    if (k < 1)      return 17'h00000;
    else if (k < 3) return 17'h00008;
    else if (k < 5) return 17'h000F8;
    else if (k < 7) return 17'h00FF8;
    else if (k < 9) return 17'h0FFF8;
    else            return 17'h1FFF8;
  endfunction

  function automatic vec_t mk(input logic v, input logic [16:0] m, input logic [16:0] eo,
                              input logic eb, input logic ed, input logic er, input string nm);
    vec_t x;
    x.valid = v; x.mask = m; x.exp_oe = eo;
    x.exp_busy = eb; x.exp_done = ed; x.exp_ready = er; x.name = nm;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_all(input string nm, input logic [16:0] eo,
                         input logic eb, input logic ed, input logic er);
    chk({nm, ".out_en"}, out_en, eo);
    chk({nm, ".busy"}, {16'h0, busy}, {16'h0, eb});
    chk({nm, ".done"}, {16'h0, done}, {16'h0, ed});
    chk({nm, ".cfg_ready"}, {16'h0, cfg_ready}, {16'h0, er});
  endtask

  // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
  task automatic apply(input vec_t v);
    vec_t x;
    cfg_valid = v.valid;
    cfg_mask  = v.mask;
    sb.push_back(v);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk_all(x.name, x.exp_oe, x.exp_busy, x.exp_done, x.exp_ready);
  endtask

  initial begin
    // Bring-up: edges 1..26 after reset release.
    for (int e = 1; e <= 26; e++)
      bringup_tbl.push_back(mk(1'b0, 17'h0, ramp_oe(e - 16), e < 25, e >= 25, e >= 25,
                               $sformatf("bringup_e%0d", e)));

    // Reduce mask to 0xFF: inputs stripped, disables immediate, then a 9-edge ramp.
    tbl.push_back(mk(1'b1, 17'h000FF, 17'h000F8, 1'b1, 1'b0, 1'b0, "reduce_acc"));
    for (int k = 1; k <= 9; k++)
      tbl.push_back(mk(1'b0, 17'h0, 17'h000F8, k < 9, k == 9, k == 9, $sformatf("reduce_k%0d", k)));

    // Re-enable all bits from target 0xF8: upper groups ramp back in.
    tbl.push_back(mk(1'b1, 17'h1FFFF, 17'h000F8, 1'b1, 1'b0, 1'b0, "reen_acc"));
    for (int k = 1; k <= 9; k++)
      tbl.push_back(mk(1'b0, 17'h0, ramp_oe(k) | 17'h000F8, k < 9, k == 9, k == 9,
                       $sformatf("reen_k%0d", k)));

    // Input-only mask: target becomes zero.
    tbl.push_back(mk(1'b1, 17'h00007, 17'h00000, 1'b1, 1'b0, 1'b0, "force_acc"));
    for (int k = 1; k <= 9; k++)
      tbl.push_back(mk(1'b0, 17'h0, 17'h00000, k < 9, k == 9, k == 9, $sformatf("force_k%0d", k)));

    // Valid held through the ramp: it is ignored until RUN, then accepted again.
    tbl.push_back(mk(1'b1, 17'h1FFF8, 17'h00000, 1'b1, 1'b0, 1'b0, "ign_acc"));
    for (int k = 1; k <= 9; k++)
      tbl.push_back(mk(1'b1, 17'h1FFF8, ramp_oe(k), k < 9, k == 9, k == 9, $sformatf("ign_k%0d", k)));
    tbl.push_back(mk(1'b1, 17'h1FFF8, 17'h1FFF8, 1'b1, 1'b0, 1'b0, "ign_run_acc"));
    for (int k = 1; k <= 3; k++)
      tbl.push_back(mk(1'b0, 17'h0, 17'h1FFF8, 1'b1, 1'b0, 1'b0, $sformatf("same_k%0d", k)));

    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_mask  = 17'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 17'h00000, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < bringup_tbl.size(); i++) apply(bringup_tbl[i]);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Async reset while RAMP holds all outputs on: clears without a clock edge.
    cfg_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 17'h00000, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("rst_hold", 17'h00000, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < bringup_tbl.size(); i++) apply(bringup_tbl[i]);

    if (sb.size() != 0) begin
      total_cnt++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
